// File: rtl/adc_sampler_defs.sv
// Shared constants for the ADC sampler: sample width, conversion phase
// lengths and the sequencer state encoding.
package adc_sampler_defs;

    localparam int unsigned DATA_W      = 8;
    localparam int unsigned CONV_CYCLES = 4;
    localparam int unsigned WAIT_CYCLES = 8;
    localparam int unsigned READ_CYCLES = 2;
    localparam int unsigned CYC_W       = 4;

    localparam logic [CYC_W-1:0] CONV_LAST = CYC_W'(CONV_CYCLES - 1);
    localparam logic [CYC_W-1:0] WAIT_LAST = CYC_W'(WAIT_CYCLES - 1);
    localparam logic [CYC_W-1:0] READ_LAST = CYC_W'(READ_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CONV  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_READ  = 3'd3,
        ST_STORE = 3'd4
    } state_t;

endpackage

// File: rtl/adc_sampler_sync_fifo.sv
// Single-clock FIFO with registered read data; a push is accepted on full
// when a pop is accepted in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] rdata_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    // On full with push+pop the pointers coincide; the read sees the old entry.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            rdata_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (do_pop) begin
                rdata_q <= mem_q[rptr_q];
                rptr_q  <= rptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o = rdata_q;
    assign count_o = count_q;

endmodule

// File: rtl/adc_sampler.sv
// Periodic parallel-ADC sampler: rate divider, conversion sequencer with
// registered strobes, threshold flag and a sample FIFO for the CPU.
module adc_sampler
    import adc_sampler_defs::*;
#(
    parameter int unsigned CLK_FREQ    = 50000000,
    parameter int unsigned SAMPLE_RATE = 10000,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [DATA_W-1:0]             threshold,
    input  logic [DATA_W-1:0]             adc_data,
    output logic                          adc_conv_n,
    output logic                          adc_rd_n,
    input  logic                          rd_en,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          over_thr,
    output logic                          overflow,
    input  logic                          clr_ovf
);

    localparam int unsigned DIV   = CLK_FREQ / SAMPLE_RATE;
    localparam int unsigned DIV_W = $clog2(DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0]  div_q;
    logic              tick;
    state_t            state_q;
    logic [CYC_W-1:0]  cyc_q;
    logic              conv_n_q;
    logic              rd_n_q;
    logic [DATA_W-1:0] sample_q;
    logic              over_thr_q;
    logic              overflow_q;
    logic              fifo_full;
    logic              store;
    logic              push;
    logic              drop;

    assign tick = enable && (div_q == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!rst || !enable || tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    assign store = (state_q == ST_STORE);
    assign push  = store && (!fifo_full || rd_en);
    assign drop  = store && fifo_full && !rd_en;

    // Ticks outside IDLE fall through the case untouched, so they are ignored.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cyc_q      <= '0;
            conv_n_q   <= 1'b1;
            rd_n_q     <= 1'b1;
            sample_q   <= '0;
            over_thr_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cyc_q <= '0;
                    if (tick) begin
                        state_q  <= ST_CONV;
                        conv_n_q <= 1'b0;
                    end
                end
                ST_CONV: begin
                    if (cyc_q == CONV_LAST) begin
                        state_q  <= ST_WAIT;
                        cyc_q    <= '0;
                        conv_n_q <= 1'b1;
                    end else begin
                        cyc_q <= cyc_q + CYC_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (cyc_q == WAIT_LAST) begin
                        state_q <= ST_READ;
                        cyc_q   <= '0;
                        rd_n_q  <= 1'b0;
                    end else begin
                        cyc_q <= cyc_q + CYC_W'(1);
                    end
                end
                ST_READ: begin
                    if (cyc_q == READ_LAST) begin
                        state_q  <= ST_STORE;
                        cyc_q    <= '0;
                        rd_n_q   <= 1'b1;
                        sample_q <= adc_data;
                    end else begin
                        cyc_q <= cyc_q + CYC_W'(1);
                    end
                end
                ST_STORE: begin
                    state_q    <= ST_IDLE;
                    over_thr_q <= (sample_q > threshold);
                end
                default: begin
                    state_q  <= ST_IDLE;
                    cyc_q    <= '0;
                    conv_n_q <= 1'b1;
                    rd_n_q   <= 1'b1;
                end
            endcase

            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clr_ovf) begin
                overflow_q <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .WIDTH(DATA_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk),
        .rst_ni (rst),
        .push_i (push),
        .pop_i  (rd_en),
        .wdata_i(sample_q),
        .rdata_o(rd_data),
        .full_o (fifo_full),
        .empty_o(empty),
        .count_o(count)
    );

    assign adc_conv_n = conv_n_q;
    assign adc_rd_n   = rd_n_q;
    assign over_thr   = over_thr_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_adc_sampler.sv
// Directed bench for adc_sampler with DIV=100 and a 16-deep FIFO.
module tb_adc_sampler;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] threshold;
    logic [7:0] adc_data;
    logic       adc_conv_n;
    logic       adc_rd_n;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       empty;
    logic [4:0] count;
    logic       over_thr;
    logic       overflow;
    logic       clr_ovf;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    adc_sampler #(
        .CLK_FREQ   (50000000),
        .SAMPLE_RATE(500000),
        .FIFO_DEPTH (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .threshold (threshold),
        .adc_data  (adc_data),
        .adc_conv_n(adc_conv_n),
        .adc_rd_n  (adc_rd_n),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .count     (count),
        .over_thr  (over_thr),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    typedef struct {
        logic [7:0] data;
        logic [7:0] thr;
        logic       exp_over;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Follows one conversion from the current negedge until the negedge after
    // STORE, measuring each strobe phase; optional rd_en/clr_ovf during STORE.
    task automatic run_conv(input logic pop_in_store, input logic clr_in_store, output int wait_cyc);
        int n;
        wait_cyc = 0;
        while (adc_conv_n !== 1'b0 && wait_cyc < 300) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("conv_start_seen", {31'd0, adc_conv_n}, 32'd0);
        if (adc_conv_n !== 1'b0) return;
        n = 0;
        while (adc_conv_n === 1'b0 && n < 20) begin @(negedge clk); n++; end
        check("conv_low_cycles", n, 4);
        n = 0;
        while (adc_rd_n === 1'b1 && adc_conv_n === 1'b1 && n < 20) begin @(negedge clk); n++; end
        check("wait_cycles", n, 8);
        n = 0;
        while (adc_rd_n === 1'b0 && n < 20) begin @(negedge clk); n++; end
        check("rd_low_cycles", n, 2);
        rd_en   = pop_in_store;
        clr_ovf = clr_in_store;
        @(negedge clk);
        rd_en   = 1'b0;
        clr_ovf = 1'b0;
    endtask

    task automatic pop(output logic [7:0] d);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        d = rd_data;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int lows;
        logic [7:0] d;

        vecs[0] = '{8'd80,  8'd9,   1'b1};
        vecs[1] = '{8'd80,  8'd80,  1'b0};
        vecs[2] = '{8'd34,  8'd33,  1'b1};
        vecs[3] = '{8'd0,   8'd0,   1'b0};
        vecs[4] = '{8'd255, 8'd254, 1'b1};
        vecs[5] = '{8'd254, 8'd255, 1'b0};

        rst = 1'b0; enable = 1'b0; threshold = '0; adc_data = '0;
        rd_en = 1'b0; clr_ovf = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_conv_n",   {31'd0, adc_conv_n}, 1);
        check("rst_rd_n",     {31'd0, adc_rd_n},   1);
        check("rst_rd_data",  {24'd0, rd_data},    0);
        check("rst_empty",    {31'd0, empty},      1);
        check("rst_count",    {27'd0, count},      0);
        check("rst_over_thr", {31'd0, over_thr},   0);
        check("rst_overflow", {31'd0, overflow},   0);
        rst = 1'b1;

        // Basic conversion, threshold compare and pop, one vector per tick.
        enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            adc_data  = vecs[i].data;
            threshold = vecs[i].thr;
            run_conv(1'b0, 1'b0, w);
            if (i == 0) check("tick_to_conv_latency", w, 100);
            check("vec_over_thr", {31'd0, over_thr}, {31'd0, vecs[i].exp_over});
            check("vec_count",    {27'd0, count},    1);
            check("vec_empty",    {31'd0, empty},    0);
            pop(d);
            check("vec_rd_data",  {24'd0, d},        {24'd0, vecs[i].data});
            check("vec_empty_after_pop", {31'd0, empty}, 1);
        end

        // Pop on empty must be ignored.
        pop(d);
        check("empty_pop_rd_data", {24'd0, d},     {24'd0, vecs[5].data});
        check("empty_pop_count",   {27'd0, count}, 0);

        // Fill to full, then one dropped sample with clr_ovf coinciding.
        threshold = 8'h1F;
        for (int i = 0; i < 17; i++) begin
            adc_data = 8'h10 + 8'(i);
            run_conv(1'b0, i == 16, w);
            if (i == 15) begin
                check("full_count",    {27'd0, count},    16);
                check("full_overflow", {31'd0, overflow}, 0);
                check("full_over_thr", {31'd0, over_thr}, 0);
            end
        end
        check("drop_count",    {27'd0, count},    16);
        check("drop_overflow", {31'd0, overflow}, 1);
        check("drop_over_thr", {31'd0, over_thr}, 1);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("clr_overflow", {31'd0, overflow}, 0);

        // Full FIFO with a pop in the STORE cycle: push and pop both accepted.
        adc_data = 8'h21;
        run_conv(1'b1, 1'b0, w);
        enable = 1'b0;
        check("pushpop_count",    {27'd0, count},    16);
        check("pushpop_overflow", {31'd0, overflow}, 0);
        check("pushpop_rd_data",  {24'd0, rd_data},  8'h10);
        for (int i = 0; i < 16; i++) begin
            pop(d);
            check("drain_order", {24'd0, d}, (i < 15) ? 32'h11 + 32'(i) : 32'h21);
        end
        check("drain_count", {27'd0, count}, 0);
        check("drain_empty", {31'd0, empty}, 1);

        // enable dropped during WAIT: sequence completes, nothing further.
        adc_data = 8'h5A; threshold = 8'hFF;
        enable = 1'b1;
        w = 0;
        while (adc_conv_n !== 1'b0 && w < 300) begin @(negedge clk); w++; end
        check("en_drop_start_latency", w, 100);
        repeat (6) @(negedge clk);
        enable = 1'b0;
        repeat (9) @(negedge clk);
        check("en_drop_count",    {27'd0, count},    1);
        check("en_drop_over_thr", {31'd0, over_thr}, 0);
        lows = 0;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            if (adc_conv_n === 1'b0) lows++;
        end
        check("en_drop_no_more_conv", lows, 0);
        check("en_drop_count_hold", {27'd0, count}, 1);

        // Reset during CONV: strobes high on that edge, FIFO cleared.
        enable = 1'b1;
        w = 0;
        while (adc_conv_n !== 1'b0 && w < 300) begin @(negedge clk); w++; end
        check("rst_conv_start_latency", w, 100);
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        check("midrst_conv_n",   {31'd0, adc_conv_n}, 1);
        check("midrst_rd_n",     {31'd0, adc_rd_n},   1);
        check("midrst_count",    {27'd0, count},      0);
        check("midrst_empty",    {31'd0, empty},      1);
        check("midrst_rd_data",  {24'd0, rd_data},    0);
        check("midrst_over_thr", {31'd0, over_thr},   0);
        rst = 1'b1;
        lows = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (adc_conv_n === 1'b0 || adc_rd_n === 1'b0) lows++;
        end
        check("midrst_no_resume",   lows, 0);
        check("midrst_count_after", {27'd0, count}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
